// File: rtl/dii_package.sv
// dii_package: debug ring flit type and the local arbiter state enum.
package dii_package;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  typedef enum logic {IDLE, LOCKED} debug_ring_arb_state_t;
endpackage

// File: rtl/debug_ring_rr_select.sv
// debug_ring_rr_select: combinational round-robin pick of the first request at or after ptr.
module debug_ring_rr_select #(
  parameter int PORTS = 2,
  localparam int PW = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PORTS-1:0] gnt,
  output logic             valid
);
  int idx;
  // Scan offsets from farthest to nearest so the closest request to ptr wins.
  always_comb begin
    gnt = '0;
    idx = 0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % PORTS;
      if (req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
      end
    end
    valid = |req;
  end
endmodule

// File: rtl/debug_ring_local_arbiter.sv
// debug_ring_local_arbiter: packet-level round-robin sharing of one ring local_in port.
// Optional per-port packet counters enabled by DEBUG_RING_ARB_STATS_EN.
module debug_ring_local_arbiter
  import dii_package::*;
#(
  parameter int PORTS     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  dii_flit [PORTS-1:0] req_in,
  output logic    [PORTS-1:0] req_in_ready,
  output dii_flit             ring_out,
  input  logic                ring_out_ready,
  output logic    [PORTS-1:0] grant
`ifdef DEBUG_RING_ARB_STATS_EN
  ,
  output logic [PORTS-1:0][CNT_WIDTH-1:0] pkt_cnt
`endif
);
  localparam int PW = $clog2(PORTS);

  if (PORTS < 2 || CNT_WIDTH < 1) begin : g_bad_param
    $error("debug_ring_local_arbiter: PORTS must be >= 2 and CNT_WIDTH >= 1");
  end

  debug_ring_arb_state_t state, state_n;
  logic [PORTS-1:0] grant_n, pick, valids;
  logic [PW-1:0] ptr, ptr_n, owner;
  logic pick_valid, xfer, done;

  always_comb begin
    valids = '0;
    for (int i = 0; i < PORTS; i++) valids[i] = req_in[i].valid;
  end

  debug_ring_rr_select #(.PORTS(PORTS)) u_sel (
    .req  (valids),
    .ptr  (ptr),
    .gnt  (pick),
    .valid(pick_valid)
  );

  always_comb begin
    owner = '0;
    for (int i = 0; i < PORTS; i++) if (grant[i]) owner = PW'(i);
  end

  // ring_out.valid comes only from the owner, never from ring_out_ready.
  always_comb begin
    ring_out = state == LOCKED ? req_in[owner] : '0;
    req_in_ready = state == LOCKED ? grant & {PORTS{ring_out_ready}} : '0;
    xfer = ring_out.valid & ring_out_ready;
    done = xfer & ring_out.last;
    state_n = state;
    grant_n = grant;
    ptr_n = ptr;
    if (state == IDLE && pick_valid) begin
      state_n = LOCKED;
      grant_n = pick;
    end
    if (done) begin
      state_n = IDLE;
      grant_n = '0;
      ptr_n = owner == PW'(PORTS - 1) ? '0 : owner + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      ptr <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      ptr <= ptr_n;
    end
  end

`ifdef DEBUG_RING_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pkt_cnt <= '0;
    else for (int i = 0; i < PORTS; i++)
      if (done && grant[i] && !(&pkt_cnt[i])) pkt_cnt[i] <= pkt_cnt[i] + 1'b1;
  end
`endif
endmodule

// File: tb/tb_debug_ring_local_arbiter.sv
// tb_debug_ring_local_arbiter: vector table, directed corner cases and a random run vs a reference model.
module tb_debug_ring_local_arbiter;
  import dii_package::*;
  localparam int P = 2, CW = 2;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  dii_flit [P-1:0] req_in;
  logic [P-1:0] req_in_ready, grant;
  dii_flit ring_out;
  logic ring_out_ready;
`ifdef DEBUG_RING_ARB_STATS_EN
  logic [P-1:0][CW-1:0] pkt_cnt;
`endif

  debug_ring_local_arbiter #(.PORTS(P), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_in        (req_in),
    .req_in_ready  (req_in_ready),
    .ring_out      (ring_out),
    .ring_out_ready(ring_out_ready),
    .grant         (grant)
`ifdef DEBUG_RING_ARB_STATS_EN
    ,
    .pkt_cnt       (pkt_cnt)
`endif
  );

  int total = 0, bad = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic l0, input logic [15:0] d0,
                       input logic v1, input logic l1, input logic [15:0] d1);
    req_in[0] = '{valid: v0, last: l0, data: d0};
    req_in[1] = '{valid: v1, last: l1, data: d1};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_in = '0;
    ring_out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic r;
    logic v0, l0; logic [15:0] d0;
    logic v1, l1; logic [15:0] d1;
    logic [1:0] g; logic rv; logic [15:0] rd; logic [1:0] rr;
  } vec_t;
  vec_t tbl[15];

  int m_owner, m_ptr;
  int m_cnt[P];
  logic [P-1:0] acc, eg, er;
  int left[P];

  initial begin
    tbl[0]  = '{0, 1,0,16'd1,  0,0,16'd0,  2'b00, 0, 16'd0,  2'b00};
    tbl[1]  = '{0, 1,0,16'd1,  0,0,16'd0,  2'b01, 1, 16'd1,  2'b01};
    tbl[2]  = '{0, 1,0,16'd2,  0,0,16'd0,  2'b01, 1, 16'd2,  2'b01};
    tbl[3]  = '{0, 1,1,16'd3,  0,0,16'd0,  2'b01, 1, 16'd3,  2'b01};
    tbl[4]  = '{0, 0,0,16'd0,  0,0,16'd0,  2'b00, 0, 16'd0,  2'b00};
    tbl[5]  = '{1, 1,0,16'd10, 1,0,16'd20, 2'b00, 0, 16'd0,  2'b00};
    tbl[6]  = '{0, 1,0,16'd10, 1,0,16'd20, 2'b00, 0, 16'd0,  2'b00};
    tbl[7]  = '{0, 1,0,16'd11, 1,0,16'd20, 2'b01, 1, 16'd11, 2'b01};
    tbl[8]  = '{0, 1,1,16'd12, 1,0,16'd20, 2'b01, 1, 16'd12, 2'b01};
    tbl[9]  = '{0, 1,1,16'd13, 1,0,16'd20, 2'b00, 0, 16'd0,  2'b00};
    tbl[10] = '{0, 1,1,16'd13, 1,0,16'd20, 2'b10, 1, 16'd20, 2'b10};
    tbl[11] = '{0, 1,1,16'd13, 1,1,16'd21, 2'b10, 1, 16'd21, 2'b10};
    tbl[12] = '{0, 1,1,16'd13, 0,0,16'd0,  2'b00, 0, 16'd0,  2'b00};
    tbl[13] = '{0, 1,1,16'd13, 0,0,16'd0,  2'b01, 1, 16'd13, 2'b01};
    tbl[14] = '{0, 0,0,16'd0,  0,0,16'd0,  2'b00, 0, 16'd0,  2'b00};

    req_in = '0;
    ring_out_ready = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst grant", 32'(grant), 0);
    chk("rst ring valid", 32'(ring_out.valid), 0);
    chk("rst ready", 32'(req_in_ready), 0);
`ifdef DEBUG_RING_ARB_STATS_EN
    chk("rst pkt_cnt", 32'(pkt_cnt), 0);
`endif
    tick();
    rst = 1'b0;
    ring_out_ready = 1'b1;

    // Test 1 and 2: single requester packet, then simultaneous requests.
    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].r;
      drive(tbl[i].v0, tbl[i].l0, tbl[i].d0, tbl[i].v1, tbl[i].l1, tbl[i].d1);
      @(negedge clk);
      chk($sformatf("vec%0d grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("vec%0d ring valid", i), 32'(ring_out.valid), 32'(tbl[i].rv));
      chk($sformatf("vec%0d ready", i), 32'(req_in_ready), 32'(tbl[i].rr));
      if (tbl[i].rv) chk($sformatf("vec%0d data", i), 32'(ring_out.data), 32'(tbl[i].rd));
      tick();
    end

    // Test 3: owner port1 stalls mid-packet while port0 waits.
    do_reset();
    drive(0, 0, 0, 1, 0, 16'd30);
    tick();
    @(negedge clk);
    chk("stall lock", 32'(grant), 2'b10);
    chk("stall first data", 32'(ring_out.data), 16'd30);
    tick();
    drive(1, 1, 16'd40, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d grant", i), 32'(grant), 2'b10);
      chk($sformatf("stall%0d ready0", i), 32'(req_in_ready[0]), 0);
      chk($sformatf("stall%0d ring valid", i), 32'(ring_out.valid), 0);
      tick();
    end
    drive(1, 1, 16'd40, 1, 1, 16'd31);
    @(negedge clk);
    chk("stall resume data", 32'(ring_out.data), 16'd31);
    chk("stall resume ready", 32'(req_in_ready), 2'b10);
    tick();
    drive(1, 1, 16'd40, 0, 0, 0);
    @(negedge clk);
    chk("stall done idle", 32'(grant), 0);
    tick();
    @(negedge clk);
    chk("stall next owner", 32'(grant), 2'b01);
    tick();
    drive(0, 0, 0, 0, 0, 0);

    // Test 4: backpressure holds the flit.
    do_reset();
    ring_out_ready = 1'b0;
    drive(1, 1, 16'hA5A5, 0, 0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d data", i), 32'(ring_out.data), 16'hA5A5);
      chk($sformatf("bp%0d valid", i), 32'(ring_out.valid), 1);
      chk($sformatf("bp%0d grant", i), 32'(grant), 2'b01);
      chk($sformatf("bp%0d ready", i), 32'(req_in_ready), 0);
      tick();
    end
    ring_out_ready = 1'b1;
    @(negedge clk);
    chk("bp accept ready", 32'(req_in_ready), 2'b01);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("bp after accept", 32'(grant), 0);
    tick();

    // Test 5: async reset while port1 holds the lock mid-packet.
    do_reset();
    drive(1, 1, 16'd1, 0, 0, 0);
    tick();
    tick();
    drive(0, 0, 0, 1, 0, 16'd50);
    tick();
    @(negedge clk);
    chk("rstmid lock", 32'(grant), 2'b10);
    tick();
    rst = 1'b1;
    #1;
    chk("rstmid grant", 32'(grant), 0);
    chk("rstmid valid", 32'(ring_out.valid), 0);
    chk("rstmid ready", 32'(req_in_ready), 0);
    tick();
    rst = 1'b0;
    drive(1, 1, 16'd60, 1, 0, 16'd51);
    @(negedge clk);
    chk("rstmid idle", 32'(grant), 0);
    tick();
    @(negedge clk);
    chk("rstmid restart port0", 32'(grant), 2'b01);
    tick();
    drive(0, 0, 0, 0, 0, 0);

`ifdef DEBUG_RING_ARB_STATS_EN
    // Test 6: five single-flit packets saturate a 2-bit counter.
    do_reset();
    drive(1, 1, 16'd7, 0, 0, 0);
    repeat (10) tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("sat pkt_cnt0", 32'(pkt_cnt[0]), 3);
    chk("sat pkt_cnt1", 32'(pkt_cnt[1]), 0);
    tick();
`endif

    // Random traffic against the reference model.
    do_reset();
    m_owner = -1;
    m_ptr = 0;
    acc = '0;
    for (int i = 0; i < P; i++) begin
      m_cnt[i] = 0;
      left[i] = 0;
    end
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < P; i++) begin
        if (acc[i]) begin
          left[i]--;
          req_in[i].valid = 1'b0;
        end
        if (!req_in[i].valid && $urandom_range(0, 2) != 0) begin
          if (left[i] == 0) left[i] = $urandom_range(1, 4);
          req_in[i].valid = 1'b1;
          req_in[i].last = left[i] == 1;
          req_in[i].data = 16'($urandom);
        end
      end
      ring_out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      er = ring_out_ready ? eg : '0;
      chk($sformatf("rnd%0d grant", c), 32'(grant), 32'(eg));
      chk($sformatf("rnd%0d ready", c), 32'(req_in_ready), 32'(er));
      chk($sformatf("rnd%0d valid", c), 32'(ring_out.valid),
          32'(m_owner >= 0 && req_in[m_owner].valid));
      if (m_owner >= 0 && req_in[m_owner].valid) begin
        chk($sformatf("rnd%0d data", c), 32'(ring_out.data), 32'(req_in[m_owner].data));
        chk($sformatf("rnd%0d last", c), 32'(ring_out.last), 32'(req_in[m_owner].last));
      end
`ifdef DEBUG_RING_ARB_STATS_EN
      for (int i = 0; i < P; i++) chk($sformatf("rnd%0d cnt%0d", c, i), 32'(pkt_cnt[i]), 32'(m_cnt[i]));
`endif
      acc = '0;
      if (m_owner < 0) begin
        for (int k = P - 1; k >= 0; k--)
          if (req_in[(m_ptr + k) % P].valid) m_owner = (m_ptr + k) % P;
      end else if (req_in[m_owner].valid && ring_out_ready) begin
        acc[m_owner] = 1'b1;
        if (req_in[m_owner].last) begin
          if (m_cnt[m_owner] < (1 << CW) - 1) m_cnt[m_owner]++;
          m_ptr = (m_owner + 1) % P;
          m_owner = -1;
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
